fe_tx_engine: RTL and testbench

- UTMI transmit-side link engine: the drive direction of the front-end interface that the sniffer path only receives on.
- Buffers one packet payload, then transmits it to the PHY using the txvalid/txready handshake: PID byte, payload bytes, optional CRC16.
- Switches the PHY opmode from non-driving to normal only for the duration of the packet.
- Sits in the fe_clk domain between the register block (already synchronised into fe_clk) and the front-end pins.

---
 rtl/fe_tx_engine.sv | 196 +++++++++++++++++++
 tb/tb_fe_tx_engine.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fe_tx_engine.sv
// fe_tx_engine: UTMI transmit-side link engine.
// Buffers one payload, then drives PID, payload and optional CRC16 to the PHY.
module fe_tx_engine #(
    parameter int pBUF_ADDR_WIDTH = 6,
    parameter int pGAP_WIDTH      = 8
) (
    input  logic                     fe_clk,
    input  logic                     reset_n,
    input  logic [7:0]               I_wr_data,
    input  logic                     I_wr,
    input  logic [3:0]               I_pid,
    input  logic                     I_crc_en,
    input  logic [pGAP_WIDTH-1:0]    I_gap,
    input  logic                     I_send,
    input  logic                     I_abort,
    input  logic                     fe_txready,
    input  logic                     fe_rxactive,
    output logic                     O_fe_txvalid,
    output logic [7:0]               O_fe_tx_data,
    output logic [1:0]               O_opmode,
    output logic                     O_busy,
    output logic                     O_done,
    output logic [pBUF_ADDR_WIDTH:0] O_buf_count,
    output logic                     O_overflow
);

    localparam int AW    = pBUF_ADDR_WIDTH;
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0]           FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]           CNT1  = (AW+1)'(1);
    localparam logic [AW-1:0]         PTR1  = AW'(1);
    localparam logic [pGAP_WIDTH-1:0] GAP1  = pGAP_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_PREP, S_PID,
        S_DATA, S_CRC_LO, S_CRC_HI, S_END
    } state_t;

    state_t state, state_nxt;

    logic [pGAP_WIDTH-1:0] gap_cnt;
    logic [3:0]            pid_q;
    logic                  crc_en_q;
    logic [15:0]           crc_q, crc_nxt;
    logic [7:0]            mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr, rd_nxt;
    logic                  send_ok, xfer, pop, push, drop;

    logic       txvalid_d, busy_d, done_d;
    logic [7:0] tx_data_d;
    logic [1:0] opmode_d;

    function automatic logic [15:0] crc_byte(input logic [15:0] c,
                                             input logic [7:0]  d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    assign send_ok = (state == S_IDLE) && I_send && !I_abort;
    assign xfer    = O_fe_txvalid && fe_txready;
    assign pop     = (state == S_DATA) && xfer;
    assign push    = (state == S_IDLE) && I_wr && !I_abort &&
                     (O_buf_count != FULL);
    assign drop    = I_wr && ((state != S_IDLE) || (O_buf_count == FULL));
    assign rd_nxt  = rd_ptr + AW'(pop);
    assign crc_nxt = pop ? crc_byte(crc_q, mem[rd_ptr]) : crc_q;

    // State register
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode; abort overrides everything outside IDLE
    always_comb begin
        state_nxt = state;
        if (I_abort && state != S_IDLE) begin
            state_nxt = S_END;
        end else begin
            unique case (state)
                S_IDLE:   if (send_ok) state_nxt = S_GAP;
                S_GAP:    if (!fe_rxactive && gap_cnt == I_gap)
                              state_nxt = S_PREP;
                S_PREP:   state_nxt = S_PID;
                S_PID:    if (xfer)
                              state_nxt = (O_buf_count != '0) ? S_DATA :
                                          crc_en_q ? S_CRC_LO : S_END;
                S_DATA:   if (xfer && O_buf_count == CNT1)
                              state_nxt = crc_en_q ? S_CRC_LO : S_END;
                S_CRC_LO: if (xfer) state_nxt = S_CRC_HI;
                S_CRC_HI: if (xfer) state_nxt = S_END;
                S_END:    state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // Next output values, derived from the state being entered
    always_comb begin
        txvalid_d = 1'b0;
        tx_data_d = 8'h00;
        opmode_d  = 2'b01;
        busy_d    = (state_nxt != S_IDLE);
        done_d    = 1'b0;
        unique case (state_nxt)
            S_PREP: opmode_d = 2'b00;
            S_PID: begin
                txvalid_d = 1'b1;
                tx_data_d = {~pid_q, pid_q};
                opmode_d  = 2'b00;
            end
            S_DATA: begin
                txvalid_d = 1'b1;
                tx_data_d = mem[rd_nxt];
                opmode_d  = 2'b00;
            end
            S_CRC_LO: begin
                txvalid_d = 1'b1;
                tx_data_d = ~crc_nxt[7:0];
                opmode_d  = 2'b00;
            end
            S_CRC_HI: begin
                txvalid_d = 1'b1;
                tx_data_d = ~crc_q[15:8];
                opmode_d  = 2'b00;
            end
            S_END: begin
                opmode_d = O_opmode;
                done_d   = (state != S_END) && !I_abort;
            end
            default: ;
        endcase
    end

    // Register all PHY-facing and status outputs
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            O_fe_txvalid <= 1'b0;
            O_fe_tx_data <= 8'h00;
            O_opmode     <= 2'b01;
            O_busy       <= 1'b0;
            O_done       <= 1'b0;
        end else begin
            O_fe_txvalid <= txvalid_d;
            O_fe_tx_data <= tx_data_d;
            O_opmode     <= opmode_d;
            O_busy       <= busy_d;
            O_done       <= done_d;
        end
    end

    // Packet context, gap counter, CRC, FIFO pointers and overflow flag
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt     <= '0;
            pid_q       <= 4'h0;
            crc_en_q    <= 1'b0;
            crc_q       <= 16'hFFFF;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            O_buf_count <= '0;
            O_overflow  <= 1'b0;
        end else begin
            if (send_ok) begin
                pid_q    <= I_pid;
                crc_en_q <= I_crc_en;
                gap_cnt  <= '0;
            end else if (state == S_GAP) begin
                gap_cnt  <= fe_rxactive ? '0 : gap_cnt + GAP1;
            end
            crc_q <= (state == S_PREP) ? 16'hFFFF : crc_nxt;
            if (I_abort) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                O_buf_count <= '0;
            end else if (push) begin
                wr_ptr      <= wr_ptr + PTR1;
                O_buf_count <= O_buf_count + CNT1;
            end else if (pop) begin
                rd_ptr      <= rd_nxt;
                O_buf_count <= O_buf_count - CNT1;
            end
            if (drop)         O_overflow <= 1'b1;
            else if (send_ok) O_overflow <= 1'b0;
        end
    end

    // Payload storage
    always_ff @(posedge fe_clk) begin
        if (push) mem[wr_ptr] <= I_wr_data;
    end

endmodule

// File: tb/tb_fe_tx_engine.sv
// tb_fe_tx_engine: randomized bench for fe_tx_engine.
// Expected byte streams come from a queue model of the packet format.
module tb_fe_tx_engine;

    logic       fe_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] I_wr_data = 8'h00;
    logic       I_wr = 1'b0;
    logic [3:0] I_pid = 4'h0;
    logic       I_crc_en = 1'b0;
    logic [7:0] I_gap = 8'h00;
    logic       I_send = 1'b0;
    logic       I_abort = 1'b0;
    logic       fe_txready;
    logic       fe_rxactive = 1'b0;
    logic       O_fe_txvalid;
    logic [7:0] O_fe_tx_data;
    logic [1:0] O_opmode;
    logic       O_busy;
    logic       O_done;
    logic [6:0] O_buf_count;
    logic       O_overflow;

    logic ready_auto = 1'b1;
    logic ready_man = 1'b1;
    int   rdy_mode = 0;
    assign fe_txready = (rdy_mode == 3) ? ready_man : ready_auto;

    int total = 0;
    int bad = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] model_buf[$];
    bit   exp_ovf = 1'b0;
    int   done_cnt = 0;
    int   vcyc = 0;
    logic prev_v = 1'b0;
    logic prev_r = 1'b0;
    logic [7:0] prev_d = 8'h00;
    int   k;
    int   len;

    fe_tx_engine dut (
        .fe_clk       (fe_clk),
        .reset_n      (reset_n),
        .I_wr_data    (I_wr_data),
        .I_wr         (I_wr),
        .I_pid        (I_pid),
        .I_crc_en     (I_crc_en),
        .I_gap        (I_gap),
        .I_send       (I_send),
        .I_abort      (I_abort),
        .fe_txready   (fe_txready),
        .fe_rxactive  (fe_rxactive),
        .O_fe_txvalid (O_fe_txvalid),
        .O_fe_tx_data (O_fe_tx_data),
        .O_opmode     (O_opmode),
        .O_busy       (O_busy),
        .O_done       (O_done),
        .O_buf_count  (O_buf_count),
        .O_overflow   (O_overflow)
    );

    always #5 fe_clk = ~fe_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit-serial reflected CRC16, poly 0xA001, init 0xFFFF
    function automatic logic [15:0] crc_ref(input logic [7:0] q[$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (q[i])
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        return c;
    endfunction

    // PHY-side ready generator
    always @(posedge fe_clk) begin
        #1;
        case (rdy_mode)
            1:       ready_auto = ~ready_auto;
            2:       ready_auto = 1'($urandom_range(0, 1));
            default: ready_auto = 1'b1;
        endcase
    end

    // Bus monitor: capture transfers, check hold-while-stalled
    always @(negedge fe_clk) begin
        if (!reset_n) begin
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            if (prev_v && !prev_r && O_fe_txvalid)
                check("hold", 32'(O_fe_tx_data), 32'(prev_d));
            if (O_fe_txvalid) begin
                vcyc++;
                check("opm_tx", 32'(O_opmode), 32'd0);
            end
            if (O_fe_txvalid && fe_txready) rx_q.push_back(O_fe_tx_data);
            if (O_done) done_cnt++;
            prev_v = O_fe_txvalid;
            prev_r = fe_txready;
            prev_d = O_fe_tx_data;
        end
    end

    task automatic wr_byte(input logic [7:0] b);
        I_wr = 1'b1;
        I_wr_data = b;
        @(posedge fe_clk);
        #1;
        I_wr = 1'b0;
        if (model_buf.size() < 64) model_buf.push_back(b);
        else exp_ovf = 1'b1;
    endtask

    // chk: 0 none, 1 latency, 2 rxactive-held gap timing
    task automatic send_and_check(input logic [3:0] pid, input bit crc,
                                  input int gap, input int chk,
                                  input int rx_cycles);
        logic [15:0] c;
        bit ok;
        int n;
        exp_q.delete();
        exp_q.push_back({~pid, pid});
        foreach (model_buf[i]) exp_q.push_back(model_buf[i]);
        if (crc) begin
            c = crc_ref(model_buf);
            exp_q.push_back(~c[7:0]);
            exp_q.push_back(~c[15:8]);
        end
        rx_q.delete();
        done_cnt = 0;
        vcyc = 0;
        I_pid = pid;
        I_crc_en = crc;
        I_gap = 8'(gap);
        I_send = 1'b1;
        @(posedge fe_clk);
        #1;
        I_send = 1'b0;
        check("ovf_clr", 32'(O_overflow), 32'd0);
        check("busy", 32'(O_busy), 32'd1);
        exp_ovf = 1'b0;
        model_buf.delete();
        if (chk == 1) begin
            check("lat_n1_opm", 32'(O_opmode), 32'd1);
            @(posedge fe_clk);
            #1;
            check("lat_n2_opm", 32'(O_opmode), 32'd0);
            check("lat_n2_v", 32'(O_fe_txvalid), 32'd0);
            @(posedge fe_clk);
            #1;
            check("lat_n3_v", 32'(O_fe_txvalid), 32'd1);
            check("lat_n3_d", 32'(O_fe_tx_data), 32'(exp_q[0]));
        end else if (chk == 2) begin
            fe_rxactive = 1'b1;
            repeat (rx_cycles) @(posedge fe_clk);
            #1;
            fe_rxactive = 1'b0;
            n = 0;
            ok = 1'b0;
            while (n < 60 && !ok) begin
                @(posedge fe_clk);
                #1;
                n++;
                if (O_fe_txvalid) ok = 1'b1;
            end
            check("gap_rise", 32'(n), 32'(gap + 2));
        end
        n = 0;
        ok = 1'b0;
        while (n < 3000 && !ok) begin
            if (!O_busy) ok = 1'b1;
            else begin
                @(posedge fe_clk);
                #1;
                n++;
            end
        end
        check("finish", 32'(ok), 32'd1);
        check("nbytes", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check("byte", 32'(rx_q[i]), 32'(exp_q[i]));
        check("done", 32'(done_cnt), 32'd1);
        check("cnt0", 32'(O_buf_count), 32'd0);
        check("ovf0", 32'(O_overflow), 32'd0);
        check("opm_idle", 32'(O_opmode), 32'd1);
        if (rdy_mode == 0) check("vcyc", 32'(vcyc), 32'(exp_q.size()));
    endtask

    initial begin
        repeat (3) @(posedge fe_clk);
        #1;
        check("rst_v", 32'(O_fe_txvalid), 32'd0);
        check("rst_d", 32'(O_fe_tx_data), 32'd0);
        check("rst_opm", 32'(O_opmode), 32'd1);
        check("rst_busy", 32'(O_busy), 32'd0);
        check("rst_done", 32'(O_done), 32'd0);
        check("rst_cnt", 32'(O_buf_count), 32'd0);
        check("rst_ovf", 32'(O_overflow), 32'd0);
        reset_n = 1'b1;
        @(posedge fe_clk);
        #1;

        rdy_mode = 0;
        send_and_check(4'h2, 1'b0, 0, 1, 0);
        send_and_check(4'h3, 1'b1, 0, 0, 0);

        for (int i = 1; i <= 4; i++) wr_byte(8'(i));
        check("cnt4", 32'(O_buf_count), 32'd4);
        rdy_mode = 1;
        send_and_check(4'hB, 1'b1, 0, 0, 0);
        rdy_mode = 0;

        for (int i = 0; i < 3; i++) wr_byte(8'($urandom));
        send_and_check(4'h3, 1'b1, 10, 2, 5);

        for (int i = 0; i < 65; i++) wr_byte(8'($urandom));
        check("full_cnt", 32'(O_buf_count), 32'd64);
        check("full_ovf", 32'(O_overflow), 32'd1);
        rdy_mode = 2;
        send_and_check(4'hB, 1'b1, 0, 0, 0);

        for (int i = 0; i < 6; i++) wr_byte(8'($urandom));
        rdy_mode = 3;
        ready_man = 1'b1;
        rx_q.delete();
        done_cnt = 0;
        I_pid = 4'h3;
        I_crc_en = 1'b1;
        I_gap = 8'h00;
        I_send = 1'b1;
        @(posedge fe_clk);
        #1;
        I_send = 1'b0;
        k = 0;
        while (k < 50 && rx_q.size() < 3) begin
            @(posedge fe_clk);
            #1;
            k++;
        end
        check("abt_reach", 32'(rx_q.size()), 32'd3);
        I_abort = 1'b1;
        ready_man = 1'b0;
        @(posedge fe_clk);
        #1;
        I_abort = 1'b0;
        check("abt_v", 32'(O_fe_txvalid), 32'd0);
        check("abt_cnt", 32'(O_buf_count), 32'd0);
        check("abt_busy", 32'(O_busy), 32'd1);
        @(posedge fe_clk);
        #1;
        check("abt_idle", 32'(O_busy), 32'd0);
        check("abt_opm", 32'(O_opmode), 32'd1);
        check("abt_done", 32'(done_cnt), 32'd0);
        check("abt_n", 32'(rx_q.size()), 32'd3);
        model_buf.delete();
        rdy_mode = 0;

        for (int i = 0; i < 5; i++) wr_byte(8'($urandom));
        I_abort = 1'b1;
        I_send = 1'b1;
        @(posedge fe_clk);
        #1;
        I_abort = 1'b0;
        I_send = 1'b0;
        check("iabt_cnt", 32'(O_buf_count), 32'd0);
        check("iabt_busy", 32'(O_busy), 32'd0);
        model_buf.delete();
        send_and_check(4'h2, 1'b0, 1, 0, 0);

        for (int i = 0; i < 3; i++) wr_byte(8'($urandom));
        rdy_mode = 3;
        ready_man = 1'b0;
        I_send = 1'b1;
        @(posedge fe_clk);
        #1;
        I_send = 1'b0;
        k = 0;
        while (k < 20 && !O_fe_txvalid) begin
            @(posedge fe_clk);
            #1;
            k++;
        end
        check("ar_pre_v", 32'(O_fe_txvalid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_v", 32'(O_fe_txvalid), 32'd0);
        check("ar_opm", 32'(O_opmode), 32'd1);
        check("ar_cnt", 32'(O_buf_count), 32'd0);
        check("ar_busy", 32'(O_busy), 32'd0);
        @(posedge fe_clk);
        #1;
        reset_n = 1'b1;
        ready_man = 1'b1;
        rdy_mode = 0;
        model_buf.delete();
        exp_ovf = 1'b0;
        @(posedge fe_clk);
        #1;

        for (int p = 0; p < 25; p++) begin
            len = $urandom_range(0, 70);
            for (int j = 0; j < len; j++) wr_byte(8'($urandom));
            check("r_cnt", 32'(O_buf_count), 32'(model_buf.size()));
            check("r_ovf", 32'(O_overflow), 32'(exp_ovf));
            rdy_mode = $urandom_range(0, 2);
            send_and_check(4'($urandom), 1'($urandom_range(0, 1)),
                           $urandom_range(0, 4), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
